// File: rtl/redundancy_switch_ctrl_if.sv
// Signal bundle between the failover sequencer and its surroundings: heartbeat
// health and switch requests in, CPU select, reset pulses and status out.
interface redundancy_switch_ctrl_if;
    logic       io_a;
    logic       io_b;
    logic       force_swi;
    logic       force_target;
    logic       com_swi;
    logic       switch;
    logic       busy;
    logic       reset_A_n;
    logic       reset_B_n;
    logic       both_dead;
    logic       req_drop;
    logic [7:0] swap_cnt;

    modport master (
        output io_a, io_b, force_swi, force_target, com_swi,
        input  switch, busy, reset_A_n, reset_B_n, both_dead, req_drop, swap_cnt
    );

    modport slave (
        input  io_a, io_b, force_swi, force_target, com_swi,
        output switch, busy, reset_A_n, reset_B_n, both_dead, req_drop, swap_cnt
    );
endinterface

// File: rtl/redundancy_switch_ctrl.sv
// Failover sequencer for the dual-CPU unit: picks the active CPU, guards every
// changeover, holds off further switching for a dwell time and resets the loser.
module redundancy_switch_ctrl #(
    parameter int unsigned FAIL_CYC  = 1000,
    parameter int unsigned GUARD_CYC = 16,
    parameter int unsigned RST_CYC   = 100,
    parameter int unsigned DWELL_CYC = 5000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    redundancy_switch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_A, G_AB, S_B, G_BA} state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] FAIL_MAX   = CNT_W'(FAIL_CYC);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_CYC);
    localparam logic [CNT_W-1:0] DWELL_LD   = CNT_W'(DWELL_CYC);

    state_t           state;
    logic [CNT_W-1:0] fail_a, fail_b;
    logic [CNT_W-1:0] guard_cnt, dwell_cnt;
    logic [CNT_W-1:0] rst_a_cnt, rst_b_cnt;
    logic             dead_a, dead_b, dwell_done;
    logic             go_ab, go_ba;
    logic             in_guard, flip, flip_to_b, flip_to_a;

    assign dead_a     = (fail_a == FAIL_MAX);
    assign dead_b     = (fail_b == FAIL_MAX);
    assign dwell_done = (dwell_cnt == '0);

    // Force, then automatic failover, then command; any one of them starts a guard.
    assign go_ab = (bus.force_swi && bus.force_target) ||
                   (dwell_done && dead_a && !dead_b) ||
                   (dwell_done && bus.com_swi && !dead_b);
    assign go_ba = (bus.force_swi && !bus.force_target) ||
                   (dwell_done && dead_b && !dead_a) ||
                   (dwell_done && bus.com_swi && !dead_a);

    assign in_guard  = (state == G_AB) || (state == G_BA);
    assign flip      = in_guard && (guard_cnt == GUARD_LAST);
    assign flip_to_b = flip && (state == G_AB);
    assign flip_to_a = flip && (state == G_BA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_a <= '0;
            fail_b <= '0;
        end else begin
            if (bus.io_a)     fail_a <= '0;
            else if (!dead_a) fail_a <= fail_a + ONE;
            if (bus.io_b)     fail_b <= '0;
            else if (!dead_b) fail_b <= fail_b + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_A;
            guard_cnt     <= '0;
            dwell_cnt     <= '0;
            bus.switch    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.both_dead <= 1'b0;
            bus.req_drop  <= 1'b0;
            bus.swap_cnt  <= '0;
        end else begin
            bus.both_dead <= dead_a & dead_b;
            bus.req_drop  <= 1'b0;
            if (!dwell_done) dwell_cnt <= dwell_cnt - ONE;
            unique case (state)
                S_A: begin
                    if (go_ab) begin
                        state     <= G_AB;
                        bus.busy  <= 1'b1;
                        guard_cnt <= '0;
                    end else if (bus.com_swi) begin
                        bus.req_drop <= 1'b1;
                    end
                end
                S_B: begin
                    if (go_ba) begin
                        state     <= G_BA;
                        bus.busy  <= 1'b1;
                        guard_cnt <= '0;
                    end else if (bus.com_swi) begin
                        bus.req_drop <= 1'b1;
                    end
                end
                G_AB, G_BA: begin
                    if (bus.com_swi) bus.req_drop <= 1'b1;
                    if (flip) begin
                        state      <= (state == G_AB) ? S_B : S_A;
                        bus.switch <= (state == G_AB);
                        bus.busy   <= 1'b0;
                        dwell_cnt  <= DWELL_LD;
                        if (bus.swap_cnt != 8'hFF) bus.swap_cnt <= bus.swap_cnt + 8'd1;
                    end else begin
                        guard_cnt <= guard_cnt + ONE;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    // Pulse stays low while the counter has more than one cycle left, giving RST_CYC low cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_a_cnt     <= '0;
            rst_b_cnt     <= '0;
            bus.reset_A_n <= 1'b1;
            bus.reset_B_n <= 1'b1;
        end else begin
            if (flip_to_b)              rst_a_cnt <= RST_LD;
            else if (rst_a_cnt != '0)   rst_a_cnt <= rst_a_cnt - ONE;
            if (flip_to_a)              rst_b_cnt <= RST_LD;
            else if (rst_b_cnt != '0)   rst_b_cnt <= rst_b_cnt - ONE;
            bus.reset_A_n <= !(flip_to_b || (rst_a_cnt > ONE));
            bus.reset_B_n <= !(flip_to_a || (rst_b_cnt > ONE));
        end
    end

endmodule

// File: tb/tb_redundancy_switch_ctrl.sv
// Directed bench for redundancy_switch_ctrl with a cycle-timeline reference model
// compared on every cycle plus hand-computed checkpoints.
module tb_redundancy_switch_ctrl;

    localparam int FAIL  = 8;
    localparam int GUARD = 4;
    localparam int RSTL  = 6;
    localparam int DWELL = 20;

    logic clk;
    logic rst;
    redundancy_switch_ctrl_if bus ();

    redundancy_switch_ctrl #(
        .FAIL_CYC (FAIL),
        .GUARD_CYC(GUARD),
        .RST_CYC  (RSTL),
        .DWELL_CYC(DWELL),
        .CNT_W    (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    // Reference model: absolute edge timeline (edge index t since reset).
    int t, run_a, run_b, flip_at, last_flip, ra_start, rb_start, m_swaps;
    bit m_side, m_guard, have_flip, ra_v, rb_v, m_drop, m_both;

    task automatic model_reset();
        t = 0; run_a = 0; run_b = 0; flip_at = 0; last_flip = 0;
        ra_start = 0; rb_start = 0; m_swaps = 0;
        m_side = 0; m_guard = 0; have_flip = 0; ra_v = 0; rb_v = 0;
        m_drop = 0; m_both = 0;
    endtask

    task automatic model_step();
        bit da, db, expired, dme, doth, go;
        t++;
        da = (run_a >= FAIL);
        db = (run_b >= FAIL);
        expired = !have_flip || (t > last_flip + DWELL);
        m_both = da && db;
        m_drop = 0;
        if (m_guard) begin
            if (bus.com_swi) m_drop = 1;
            if (t == flip_at) begin
                m_guard = 0;
                m_side = !m_side;
                if (m_swaps < 255) m_swaps++;
                have_flip = 1;
                last_flip = t;
                if (m_side) begin ra_v = 1; ra_start = t; end
                else        begin rb_v = 1; rb_start = t; end
            end
        end else begin
            dme  = m_side ? db : da;
            doth = m_side ? da : db;
            go = (bus.force_swi && (bus.force_target != m_side)) ||
                 (expired && dme && !doth) ||
                 (expired && bus.com_swi && !doth);
            if (go) begin
                m_guard = 1;
                flip_at = t + GUARD;
            end else if (bus.com_swi) begin
                m_drop = 1;
            end
        end
        run_a = bus.io_a ? 0 : run_a + 1;
        run_b = bus.io_b ? 0 : run_b + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_switch",    bus.switch,    m_side);
            chk("m_busy",      bus.busy,      m_guard);
            chk("m_reset_A_n", bus.reset_A_n, !(ra_v && (t - ra_start) < RSTL));
            chk("m_reset_B_n", bus.reset_B_n, !(rb_v && (t - rb_start) < RSTL));
            chk("m_both_dead", bus.both_dead, m_both);
            chk("m_req_drop",  bus.req_drop,  m_drop);
            chk("m_swap_cnt",  bus.swap_cnt,  m_swaps);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n, c0;

    initial begin
        rst = 1'b1;
        bus.io_a = 1'b1; bus.io_b = 1'b1;
        bus.force_swi = 1'b0; bus.force_target = 1'b0; bus.com_swi = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("rst_switch", bus.switch, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_reset_A_n", bus.reset_A_n, 1);
        chk("rst_reset_B_n", bus.reset_B_n, 1);
        chk("rst_swap_cnt", bus.swap_cnt, 0);
        tick(50);
        chk("idle_switch", bus.switch, 0);
        chk("idle_swap_cnt", bus.swap_cnt, 0);

        // CPU A dies: 8 low samples, one cycle to react, 4 guard cycles.
        bus.io_a = 1'b0;
        n = 0;
        while (!bus.busy && n < 40) begin tick(1); n++; end
        chk("auto_busy_latency", n, 9);
        n = 0;
        while (bus.busy && n < 40) begin tick(1); n++; end
        chk("auto_busy_len", n, 4);
        chk("auto_switch", bus.switch, 1);
        chk("auto_reset_A_n_low", bus.reset_A_n, 0);
        c0 = cyc;
        bus.io_a = 1'b1; bus.io_b = 1'b0;
        n = 0;
        while (!bus.reset_A_n && n < 40) begin tick(1); n++; end
        chk("auto_reset_A_len", n, 6);
        chk("auto_swap_cnt", bus.swap_cnt, 1);

        // CPU B dead early, but dwell blocks the flip until 21 edges after the last one.
        n = 0;
        while (!bus.busy && n < 60) begin tick(1); n++; end
        chk("dwell_busy_delay", cyc - c0, 21);
        n = 0;
        while (bus.busy && n < 40) begin tick(1); n++; end
        chk("dwell_switch", bus.switch, 0);
        chk("dwell_reset_B_n_low", bus.reset_B_n, 0);
        chk("dwell_swap_cnt", bus.swap_cnt, 2);

        // Both dead: hold, then force wins despite both_dead and active dwell.
        bus.io_a = 1'b0;
        tick(10);
        chk("both_dead", bus.both_dead, 1);
        chk("both_dead_switch", bus.switch, 0);
        bus.force_swi = 1'b1; bus.force_target = 1'b1;
        tick(1);
        chk("force_busy", bus.busy, 1);
        tick(4);
        chk("force_switch", bus.switch, 1);
        chk("force_swap_cnt", bus.swap_cnt, 3);
        bus.force_swi = 1'b0;

        // Command rejected inside dwell, then inside a guard.
        bus.io_a = 1'b1; bus.io_b = 1'b1;
        tick(2);
        bus.com_swi = 1'b1;
        tick(1);
        bus.com_swi = 1'b0;
        chk("dwell_req_drop", bus.req_drop, 1);
        chk("dwell_com_busy", bus.busy, 0);
        tick(1);
        chk("dwell_req_drop_end", bus.req_drop, 0);
        bus.force_swi = 1'b1; bus.force_target = 1'b0;
        tick(1);
        bus.force_swi = 1'b0; bus.com_swi = 1'b1;
        tick(1);
        bus.com_swi = 1'b0;
        chk("guard_req_drop", bus.req_drop, 1);
        chk("guard_busy", bus.busy, 1);
        n = 0;
        while (bus.busy && n < 40) begin tick(1); n++; end
        chk("guard_switch", bus.switch, 0);
        chk("guard_swap_cnt", bus.swap_cnt, 4);

        // Asynchronous reset on guard cycle 2 of G_AB.
        bus.force_swi = 1'b1; bus.force_target = 1'b1;
        tick(2);
        chk("pre_rst_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_switch", bus.switch, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_reset_A_n", bus.reset_A_n, 1);
        chk("async_reset_B_n", bus.reset_B_n, 1);
        chk("async_swap_cnt", bus.swap_cnt, 0);
        bus.force_swi = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("post_rst_switch", bus.switch, 0);
        chk("post_rst_busy", bus.busy, 0);

        // Accepted command with dwell expired and both CPUs alive.
        bus.com_swi = 1'b1;
        tick(1);
        bus.com_swi = 1'b0;
        chk("com_ok_busy", bus.busy, 1);
        chk("com_ok_no_drop", bus.req_drop, 0);
        n = 0;
        while (bus.busy && n < 40) begin tick(1); n++; end
        chk("com_ok_switch", bus.switch, 1);
        chk("com_ok_swap_cnt", bus.swap_cnt, 1);
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
